cfu_requant_packer: RTL and testbench
=====================================

Name: cfu_requant_packer

Overview:
- Downstream stage of the SIMD int8 MAC CFU.
- Consumes 32-bit signed dot-product accumulators and applies TFLite-style requantization: bias add, fixed-point multiply, rounding shift, output offset and activation clamp.
- Packs four int8 results per 32-bit word for store-back by the CPU.
- Valid/ready on both sides; configuration through a simple write port.

Parameters:
- LANES, 4, int8 results packed per output word; lane 0 in bits [7:0].
- SAT_CNT_W, 16, width of the saturation counter (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration write strobe
- cfg_ready  out  1  high only when the pipeline and packer are empty
- cfg_addr  in  3  register select: 0 bias, 1 multiplier, 2 shift, 3 output_offset, 4 act_min/act_max
- cfg_data  in  32  write data
- in_valid  in  1  accumulator valid
- in_ready  out  1  stage can accept an accumulator
- in_acc  in  32  signed accumulator
- flush  in  1  one-cycle pulse: emit a partially filled word
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  32  {lane3,lane2,lane1,lane0}

Behaviour:
- Reset values: out_valid=0, out_data=0, lane index=0, all stage valids=0.
- Config reset values: bias=0, multiplier=0x40000000, shift=0, output_offset=0, act_min=-128, act_max=127.
- Config write:
  - Accepted when cfg_valid & cfg_ready.
  - Takes effect the following cycle.
  - Data fields: shift = cfg_data[4:0], a right shift 0..31; output_offset = cfg_data[8:0] signed; act_min = cfg_data[7:0], act_max = cfg_data[15:8], both signed.
- Pipeline: 3 register stages. Advance = ~stall. in_ready = ~stall.
  - S1: sum = in_acc + bias, 32-bit wrap.
  - S2: SRDHM(sum, mult).
    - If sum == mult == 0x80000000, result = 0x7FFFFFFF.
    - Otherwise p = 64-bit signed product; nudge = p>=0 ? 2^30 : 1-2^30; result = (p+nudge)/2^31, truncated toward zero.
  - S3: round half away from zero by 2^shift.
    - mask = 2^shift - 1; rem = x & mask; thr = (mask>>1) + (x<0).
    - r = (x >>> shift) + (rem > thr).
  - Then v = r + output_offset, clamped to [act_min, act_max], written to the current packer lane.
- Latency: accumulator accepted at cycle N is in its lane at N+3 when there is no stall.
- Packer:
  - Lane index increments per result.
  - On the LANES-th result, the word moves to the output register and the index resets to 0.
  - Unfilled lanes read 0.
- Output register:
  - out_valid holds until out_valid & out_ready.
  - Data is stable while out_valid=1 and out_ready=0.
- Stall condition: S3 holds a result that would complete a word (or a flush is pending) AND out_valid=1 AND out_ready=0. During a stall, all stages freeze and in_ready=0.
- Draining: if out_ready=1 in the same cycle a new word completes, the new word loads with no bubble.
- Flush:
  - Registered as pending.
  - Takes effect once S1–S3 have drained.
  - If the lane index is >0, emits the partial word; if 0, it is a no-op.
  - A flush arriving while in_valid=1 is ordered after that accumulator.
- cfg_ready = no stage valid & lane index==0 & ~out_valid & no flush pending.
- act_min > act_max: result = act_max (the max clamp is applied last).
- Reset mid-operation discards in-flight items, partial lanes and the pending flush. Configuration registers return to their reset values.

Optional Feature:
- Macro: REQUANT_SAT_COUNT_EN.
- When defined:
  - Adds output sat_count[SAT_CNT_W-1:0].
  - Increments on every result where the clamp changed the value.
  - Saturates at all-ones.
  - Cleared by reset and by a config write to cfg_addr 5.
- When undefined:
  - No port and no counter logic.
  - A write to cfg_addr 5 is accepted and ignored.

Test Plan:
- Defaults, accs 100, 200, -4, 0 -> single word out_data=0x00FE6432, out_valid exactly 3 cycles after the 4th accept.
- output_offset=-128, multiplier=0x7FFFFFFF, accs 1000, -1000, then flush -> lanes 127, -128 -> out_data=0x0000807F.
- Defaults with shift=2, accs 20, -20, 6, -6 -> lanes 3, -3, 1, -1 -> out_data=0xFF01FD03.
- multiplier=0x80000000, acc=0x80000000 -> SRDHM saturates to 0x7FFFFFFF -> lane 127; with REQUANT_SAT_COUNT_EN, sat_count=1.
- Backpressure: out_ready=0 while streaming 8 accs of 1..8 with multiplier 0x7FFFFFFF.
  - in_ready drops once the second word is ready to complete.
  - Release out_ready -> words 0x04030201 then 0x08070605, no loss or duplication.
- Reset asserted with 2 lanes filled and 2 in flight -> out_valid=0; next 4 accs 1..4 produce 0x04030201; cfg_ready=1 after drain.

Source files
------------

// File: rtl/cfu_requant_packer_if.sv
// Handshake bundle for cfu_requant_packer: config write port, accumulator
// input stream, flush pulse and packed int8 output stream.
interface cfu_requant_packer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output cfg_valid, cfg_addr, cfg_data, in_valid, in_acc, flush, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, in_valid, in_acc, flush, out_ready,
        output cfg_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/cfu_requant_packer.sv
// TFLite-style requantizer (bias, SRDHM, rounding shift, offset, clamp) that packs
// LANES int8 results per output word. Optional clamp counter: REQUANT_SAT_COUNT_EN.
module cfu_requant_packer #(
    parameter int LANES = 4
`ifdef REQUANT_SAT_COUNT_EN
  , parameter int SAT_CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    cfu_requant_packer_if.slave   bus
`ifdef REQUANT_SAT_COUNT_EN
  , output logic [SAT_CNT_W-1:0]  sat_count
`endif
);

    localparam int STAGES = 2;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
    localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

    typedef struct packed {
        logic [31:0] bias;
        logic [31:0] mult;
        logic [4:0]  shift;
        logic [8:0]  out_off;
        logic [7:0]  act_min;
        logic [7:0]  act_max;
    } cfg_t;

    cfg_t                    cfg;
    logic [STAGES:1]         vld_pipe;
    logic signed [31:0]      s1_sum;
    logic signed [31:0]      s2_x;
    logic [LANES-1:0][7:0]   lanes;
    logic [LANES-1:0][7:0]   word_next;
    logic [IDX_W-1:0]        lane_idx;
    logic                    flush_pend;

    logic                    accept, cfg_we, stall, out_busy;
    logic                    word_done, flush_fire, flush_emit;

    // datapath
    logic signed [63:0]      prod, nudged;
    logic signed [31:0]      srdhm;
    logic [31:0]             mask, rem, thr;
    logic                    rnd_up;
    logic signed [31:0]      shifted, r;
    logic signed [33:0]      v, lo_val;
    logic                    lo_clip, hi_clip;
    logic [7:0]              res8;

    assign word_done  = vld_pipe[2] && (lane_idx == IDX_W'(LANES-1));
    // A flush only acts once everything accepted before it has reached the packer.
    assign flush_fire = flush_pend && (vld_pipe == '0);
    assign flush_emit = flush_fire && (lane_idx != '0);
    assign out_busy   = bus.out_valid && !bus.out_ready;
    assign stall      = (word_done || flush_emit) && out_busy;

    // Inputs are held off while a flush is pending so it stays ordered behind them.
    assign bus.in_ready  = !stall && !flush_pend;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.cfg_ready = (vld_pipe == '0) && (lane_idx == '0) && !bus.out_valid && !flush_pend;
    assign cfg_we        = bus.cfg_valid && bus.cfg_ready;

    always_comb begin
        prod   = 64'($signed(s1_sum)) * 64'($signed(cfg.mult));
        nudged = prod + (prod[63] ? NUDGE_NEG : NUDGE_POS);
        // Divide by 2^31 truncating toward zero; the only overflow case is pinned.
        if (s1_sum == 32'h8000_0000 && cfg.mult == 32'h8000_0000)
            srdhm = 32'sh7FFF_FFFF;
        else
            srdhm = 32'((nudged + (nudged[63] ? 64'sh7FFF_FFFF : 64'sh0)) >>> 31);
    end

    always_comb begin
        mask    = (32'd1 << cfg.shift) - 32'd1;
        rem     = s2_x & mask;
        thr     = (mask >> 1) + {31'd0, s2_x[31]};
        rnd_up  = rem > thr;
        shifted = s2_x >>> cfg.shift;
        r       = shifted + $signed({31'd0, rnd_up});
        v       = 34'(r) + 34'($signed(cfg.out_off));
        lo_clip = v < 34'($signed(cfg.act_min));
        lo_val  = lo_clip ? 34'($signed(cfg.act_min)) : v;
        // Max clamp last, so an inverted range always yields act_max.
        hi_clip = lo_val > 34'($signed(cfg.act_max));
        res8    = hi_clip ? cfg.act_max : (lo_clip ? cfg.act_min : v[7:0]);
    end

    always_comb begin
        word_next           = lanes;
        word_next[lane_idx] = res8;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg.bias      <= '0;
            cfg.mult      <= 32'h4000_0000;
            cfg.shift     <= '0;
            cfg.out_off   <= '0;
            cfg.act_min   <= 8'h80;
            cfg.act_max   <= 8'h7F;
            vld_pipe      <= '0;
            s1_sum        <= '0;
            s2_x          <= '0;
            lanes         <= '0;
            lane_idx      <= '0;
            flush_pend    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            if (cfg_we) begin
                case (bus.cfg_addr)
                    3'd0: cfg.bias    <= bus.cfg_data;
                    3'd1: cfg.mult    <= bus.cfg_data;
                    3'd2: cfg.shift   <= bus.cfg_data[4:0];
                    3'd3: cfg.out_off <= bus.cfg_data[8:0];
                    3'd4: begin
                        cfg.act_min <= bus.cfg_data[7:0];
                        cfg.act_max <= bus.cfg_data[15:8];
                    end
                    default: ;
                endcase
            end

            if (!stall) begin
                vld_pipe[1] <= accept;
                s1_sum      <= bus.in_acc + cfg.bias;
                vld_pipe[2] <= vld_pipe[1];
                s2_x        <= srdhm;
            end

            if (flush_fire && !stall) flush_pend <= 1'b0;
            if (bus.flush)            flush_pend <= 1'b1;

            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

            // Loading the output register takes priority over the consumer's clear.
            if (vld_pipe[2] && !stall) begin
                if (word_done) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= word_next;
                    lanes         <= '0;
                    lane_idx      <= '0;
                end else begin
                    lanes    <= word_next;
                    lane_idx <= lane_idx + IDX_W'(1);
                end
            end else if (flush_emit && !stall) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= lanes;
                lanes         <= '0;
                lane_idx      <= '0;
            end
        end
    end

`ifdef REQUANT_SAT_COUNT_EN
    logic sat_hit;
    assign sat_hit = hi_clip ? (v != 34'($signed(cfg.act_max))) : lo_clip;

    always_ff @(posedge clk) begin
        if (reset)
            sat_count <= '0;
        else if (cfg_we && bus.cfg_addr == 3'd5)
            sat_count <= '0;
        else if (vld_pipe[2] && !stall && sat_hit && !(&sat_count))
            sat_count <= sat_count + SAT_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_cfu_requant_packer.sv
// Directed bench for cfu_requant_packer with hand-computed packed words.
module tb_cfu_requant_packer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    cfu_requant_packer_if bus();
`ifdef REQUANT_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    cfu_requant_packer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef REQUANT_SAT_COUNT_EN
      , .sat_count (sat_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.cfg_valid = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
        bus.in_valid = 0;  bus.in_acc = 0;   bus.flush = 0;
        bus.out_ready = 1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic cfg_wr(input logic [2:0] addr, input logic [31:0] data);
        bit ok = 0;
        bus.cfg_addr = addr; bus.cfg_data = data; bus.cfg_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = bus.cfg_ready; tick();
        end
        bus.cfg_valid = 0;
        if (!ok) chk("cfg_timeout", 0, 1);
    endtask

    task automatic send(input logic [31:0] acc);
        bit ok = 0;
        bus.in_acc = acc; bus.in_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = bus.in_ready; tick();
        end
        bus.in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic pulse_flush();
        bus.flush = 1; tick(); bus.flush = 0;
    endtask

    task automatic wait_word(output logic [31:0] d, output bit got, output int waited);
        got = 0; d = '0; waited = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                d = bus.out_data; got = 1; waited = i; break;
            end
        end
        tick();
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        bit          got;
        int          waited, seen;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  bus.out_data, 0);
        chk("rst_in_ready",  32'(bus.in_ready), 1);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        tick();

        // defaults: x/2 -> 50, 100, -2, 0; word exactly 3 cycles after last accept
        send(100); send(200); send(-4); send(0);
        @(negedge clk);
        @(negedge clk); chk("t1_lat2_valid", 32'(bus.out_valid), 0);
        @(negedge clk); chk("t1_lat3_valid", 32'(bus.out_valid), 1);
        chk("t1_word", bus.out_data, 32'h00FE6432);
        tick();
        @(negedge clk); chk("t1_single", 32'(bus.out_valid), 0);
        tick();

        // offset -128, mult ~1.0: 872 -> 127, -1128 -> -128, partial word via flush
        do_reset();
        cfg_wr(3, 32'h0000_0180);
        cfg_wr(1, 32'h7FFF_FFFF);
        send(1000); send(-1000);
        @(negedge clk); chk("t2_cfg_busy", 32'(bus.cfg_ready), 0);
        tick();
        pulse_flush();
        wait_word(d, got, waited);
        chk("t2_got", 32'(got), 1);
        chk("t2_word", d, 32'h0000807F);
`ifdef REQUANT_SAT_COUNT_EN
        chk("t2_sat", 32'(sat_count), 2);
`endif
        tick(); tick();
        @(negedge clk); chk("t2_cfg_idle", 32'(bus.cfg_ready), 1);
        tick();

        // shift 2, half away from zero: 10,-10,3,-3 -> 3,-3,1,-1
        do_reset();
        cfg_wr(2, 2);
        send(20); send(-20); send(6); send(-6);
        wait_word(d, got, waited);
        chk("t3_got", 32'(got), 1);
        chk("t3_word", d, 32'hFF01FD03);

        // SRDHM overflow case saturates to INT32_MAX -> 127
        do_reset();
        cfg_wr(1, 32'h8000_0000);
        send(32'h8000_0000);
        pulse_flush();
        wait_word(d, got, waited);
        chk("t4_got", 32'(got), 1);
        chk("t4_word", d, 32'h0000007F);
`ifdef REQUANT_SAT_COUNT_EN
        chk("t4_sat", 32'(sat_count), 1);
`endif
        // flush with no lanes filled is a no-op
        pulse_flush();
        count_valid(8, seen);
        chk("flush_noop", 32'(seen), 0);
        // addr 5 write is accepted
        cfg_wr(5, 0);
        @(negedge clk); chk("a5_cfg_ready", 32'(bus.cfg_ready), 1);
`ifdef REQUANT_SAT_COUNT_EN
        chk("a5_sat_clr", 32'(sat_count), 0);
`endif
        tick();

        // inverted clamp range (min 10, max 5) always yields max
        do_reset();
        cfg_wr(4, 32'h0000_050A);
        send(100); send(-100);
        pulse_flush();
        wait_word(d, got, waited);
        chk("clamp_inv_word", d, 32'h00000505);

        // backpressure: 8 accs, second word held off until consumer is ready
        do_reset();
        cfg_wr(1, 32'h7FFF_FFFF);
        bus.out_ready = 0;
        for (int k = 1; k <= 8; k++) send(32'(k));
        tick(); tick(); tick();
        @(negedge clk);
        chk("t5_in_ready", 32'(bus.in_ready), 0);
        chk("t5_hold_valid", 32'(bus.out_valid), 1);
        chk("t5_hold_word", bus.out_data, 32'h04030201);
        tick();
        bus.out_ready = 1;
        wait_word(d, got, waited);
        chk("t5_word0", d, 32'h04030201);
        wait_word(d, got, waited);
        chk("t5_word1", d, 32'h08070605);
        chk("t5_nobubble", 32'(waited), 0);
        @(negedge clk);
        chk("t5_nodup", 32'(bus.out_valid), 0);
        chk("t5_in_ready_back", 32'(bus.in_ready), 1);
        tick();

        // reset with 2 lanes filled and 2 in flight discards everything
        do_reset();
        cfg_wr(1, 32'h7FFF_FFFF);
        send(10); send(20); send(30); send(40);
        reset = 1; tick(); reset = 0;
        @(negedge clk);
        chk("t6_out_valid", 32'(bus.out_valid), 0);
        chk("t6_cfg_ready", 32'(bus.cfg_ready), 1);
        tick();
        count_valid(6, seen);
        chk("t6_no_word", 32'(seen), 0);
        cfg_wr(1, 32'h7FFF_FFFF);
        send(1); send(2); send(3); send(4);
        wait_word(d, got, waited);
        chk("t6_word", d, 32'h04030201);
        tick();
        @(negedge clk);
        chk("t6_cfg_drained", 32'(bus.cfg_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
